// File: rtl/jtag_pkg.sv
// Shared JTAG constants and types.
// Used by the TDO capture block and the player.
package jtag_pkg;

    localparam int DEPTH_DEFAULT = 16;
    localparam int BYTE_W        = 8;
    localparam int BIT_CNT_W     = 3;

    typedef logic [BYTE_W-1:0] byte_t;

endpackage

// File: rtl/jtag_tdo_capture_fifo.sv
// Synchronous first-word-fall-through byte FIFO
// with occupancy count and sticky overflow.
module capture_fifo
    import jtag_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       wr_en_i,
    input  byte_t                      wr_data_i,
    input  logic                       rd_en_i,
    output byte_t                      rd_data_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow_o
);

    localparam int AW = $clog2(DEPTH);

    byte_t        mem [DEPTH];
    logic [AW:0]  wr_q;
    logic [AW:0]  rd_q;
    logic         ovf_q;
    logic         do_rd;
    logic         do_wr;

    // Extra pointer bit lets the difference reach DEPTH.
    assign count_o    = wr_q - rd_q;
    assign empty_o    = (count_o == '0);
    assign full_o     = (count_o == (AW+1)'(DEPTH));
    assign do_rd      = rd_en_i & ~empty_o;
    assign do_wr      = wr_en_i & (~full_o | do_rd);
    assign rd_data_o  = empty_o ? '0 : mem[rd_q[AW-1:0]];
    assign overflow_o = ovf_q;

    // Pointer and sticky overflow update.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (do_wr) begin
                wr_q <= wr_q + 1'b1;
            end
            if (do_rd) begin
                rd_q <= rd_q + 1'b1;
            end
            if (wr_en_i && !do_wr) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Storage write; contents are qualified by the pointers.
    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem[wr_q[AW-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/jtag_tdo_capture.sv
// Samples TDO on TCK rising edges, assembles bytes
// and queues them in a FWFT FIFO for the host.
module jtag_tdo_capture
    import jtag_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEFAULT,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                       clk_in,
    input  logic                       rst,
    input  logic                       tck,
    input  logic                       tdo,
    input  logic                       capture_en,
    input  logic                       flush,
    input  logic                       rd_en,
    output logic [BYTE_W-1:0]          data_out,
    output logic                       empty_fifo,
    output logic                       full_fifo,
    output logic [$clog2(DEPTH):0]     data_count,
    output logic                       overflow,
    output logic [BIT_CNT_W-1:0]       last_bits
);

    logic                  tck_q;
    logic                  sample;
    logic [BIT_CNT_W-1:0]  bit_cnt_q;
    logic [BIT_CNT_W-1:0]  bit_cnt_d;
    byte_t                 asm_q;
    byte_t                 asm_d;
    logic                  push_q;
    logic                  push_d;
    byte_t                 push_data_q;
    byte_t                 push_data_d;
    logic [BIT_CNT_W-1:0]  last_bits_q;
    logic [BIT_CNT_W-1:0]  last_bits_d;
    byte_t                 shifted;
    logic [BIT_CNT_W:0]    cnt_after;
    logic [BIT_CNT_W-1:0]  idx;

    assign sample    = tck & ~tck_q & capture_en;
    assign idx       = LSB_FIRST ? bit_cnt_q : ~bit_cnt_q;
    assign last_bits = last_bits_q;

    // Fold in the current bit first, then decide on a push.
    always_comb begin
        shifted   = asm_q;
        cnt_after = {1'b0, bit_cnt_q};
        if (sample) begin
            if (bit_cnt_q == '0) begin
                shifted = '0;
            end
            shifted[idx] = tdo;
            cnt_after    = {1'b0, bit_cnt_q} + (BIT_CNT_W+1)'(1);
        end
        asm_d       = shifted;
        bit_cnt_d   = cnt_after[BIT_CNT_W-1:0];
        push_d      = 1'b0;
        push_data_d = shifted;
        last_bits_d = last_bits_q;
        if (cnt_after[BIT_CNT_W]) begin
            push_d = 1'b1;
            if (flush) begin
                last_bits_d = '0;
            end
        end else if (flush) begin
            last_bits_d = cnt_after[BIT_CNT_W-1:0];
            bit_cnt_d   = '0;
            asm_d       = '0;
            if (cnt_after != '0) begin
                push_d = 1'b1;
            end
        end
    end

    // Edge detector, assembly state and pending push.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            tck_q       <= 1'b0;
            bit_cnt_q   <= '0;
            asm_q       <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            last_bits_q <= '0;
        end else begin
            tck_q       <= tck;
            bit_cnt_q   <= bit_cnt_d;
            asm_q       <= asm_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            last_bits_q <= last_bits_d;
        end
    end

    capture_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i      (clk_in),
        .rst_i      (rst),
        .wr_en_i    (push_q),
        .wr_data_i  (push_data_q),
        .rd_en_i    (rd_en),
        .rd_data_o  (data_out),
        .empty_o    (empty_fifo),
        .full_o     (full_fifo),
        .count_o    (data_count),
        .overflow_o (overflow)
    );

endmodule

// File: tb/tb_jtag_tdo_capture.sv
// Directed bench for jtag_tdo_capture:
// vector table plus multi-cycle corner sequences.
module tb_jtag_tdo_capture;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       tck = 1'b0;
    logic       tdo = 1'b0;
    logic       capture_en = 1'b0;
    logic       flush = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] data_out;
    logic       empty_fifo;
    logic       full_fifo;
    logic [4:0] data_count;
    logic       overflow;
    logic [2:0] last_bits;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        int         nbits;
        logic [7:0] bits;
        bit         do_flush;
        logic [7:0] exp_data;
        int         exp_last;
    } vec_t;

    vec_t vecs[7];

    jtag_tdo_capture #(
        .DEPTH     (16),
        .LSB_FIRST (1'b1)
    ) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .tck        (tck),
        .tdo        (tdo),
        .capture_en (capture_en),
        .flush      (flush),
        .rd_en      (rd_en),
        .data_out   (data_out),
        .empty_fifo (empty_fifo),
        .full_fifo  (full_fifo),
        .data_count (data_count),
        .overflow   (overflow),
        .last_bits  (last_bits)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        tdo = b;
        tck = 1'b1;
        tick();
        tck = 1'b0;
        tick();
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            send_bit(v[i]);
        end
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
    endtask

    task automatic pop_chk(input string name, input logic [7:0] exp);
        chk(name, int'(data_out), int'(exp));
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8, 8'h4D, 1'b0, 8'h4D, 0};
        vecs[1] = '{3, 8'h07, 1'b1, 8'h07, 3};
        vecs[2] = '{5, 8'h15, 1'b1, 8'h15, 5};
        vecs[3] = '{1, 8'h01, 1'b1, 8'h01, 1};
        vecs[4] = '{7, 8'h7F, 1'b1, 8'h7F, 7};
        vecs[5] = '{8, 8'hA5, 1'b0, 8'hA5, 0};
        vecs[6] = '{8, 8'h00, 1'b0, 8'h00, 0};

        capture_en = 1'b1;
        do_reset();
        chk("rst_empty", int'(empty_fifo), 1);
        chk("rst_full", int'(full_fifo), 0);
        chk("rst_data", int'(data_out), 0);
        chk("rst_count", int'(data_count), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_last", int'(last_bits), 0);

        // pop while empty is ignored
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("rd_empty_count", int'(data_count), 0);
        chk("rd_empty_flag", int'(empty_fifo), 1);

        for (int v = 0; v < 7; v++) begin
            send_bits(vecs[v].bits, vecs[v].nbits);
            if (vecs[v].do_flush) begin
                do_flush();
                chk($sformatf("vec%0d_last", v), int'(last_bits),
                    vecs[v].exp_last);
            end
            chk($sformatf("vec%0d_empty", v), int'(empty_fifo), 0);
            chk($sformatf("vec%0d_count", v), int'(data_count), 1);
            pop_chk($sformatf("vec%0d_data", v), vecs[v].exp_data);
            chk($sformatf("vec%0d_drain", v), int'(empty_fifo), 1);
            chk($sformatf("vec%0d_zero", v), int'(data_out), 0);
        end

        // second flush with nothing pending
        send_bits(8'h07, 3);
        do_flush();
        chk("fl1_last", int'(last_bits), 3);
        pop_chk("fl1_data", 8'h07);
        do_flush();
        chk("fl2_empty", int'(empty_fifo), 1);
        chk("fl2_last", int'(last_bits), 0);

        // flush on the 8th sample: exactly one push
        send_bits(8'h4D, 7);
        tdo = 1'b1;
        tck = 1'b1;
        flush = 1'b1;
        tick();
        tck = 1'b0;
        flush = 1'b0;
        tick();
        chk("flc_count", int'(data_count), 1);
        chk("flc_last", int'(last_bits), 0);
        tick();
        tick();
        chk("flc_count2", int'(data_count), 1);
        pop_chk("flc_data", 8'hCD);
        chk("flc_drain", int'(empty_fifo), 1);

        // capture_en low between bits 3 and 4
        send_bits(8'h05, 3);
        capture_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_bit(1'b1);
        end
        capture_en = 1'b1;
        chk("gate_count", int'(data_count), 0);
        send_bits(8'h09, 5);
        chk("gate_count2", int'(data_count), 1);
        pop_chk("gate_data", 8'h4D);

        // reset mid-byte
        send_bits(8'h1F, 5);
        do_reset();
        send_bits(8'hFF, 8);
        chk("rmb_count", int'(data_count), 1);
        pop_chk("rmb_data", 8'hFF);
        chk("rmb_drain", int'(empty_fifo), 1);

        // reset during the pending push cycle
        send_bits(8'h3C, 7);
        tdo = 1'b0;
        tck = 1'b1;
        tick();
        tck = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("rmp_count", int'(data_count), 0);
        chk("rmp_empty", int'(empty_fifo), 1);
        send_bits(8'hFF, 8);
        pop_chk("rmp_next", 8'hFF);

        // overflow: 17 bytes into 16 slots
        do_reset();
        for (int i = 0; i < 17; i++) begin
            send_bits(8'(i * 3 + 1), 8);
        end
        chk("ovf_full", int'(full_fifo), 1);
        chk("ovf_count", int'(data_count), 16);
        chk("ovf_flag", int'(overflow), 1);
        for (int i = 0; i < 16; i++) begin
            pop_chk($sformatf("ovf_rd%0d", i), 8'(i * 3 + 1));
        end
        chk("ovf_drain", int'(empty_fifo), 1);
        chk("ovf_sticky", int'(overflow), 1);

        // push and pop together while full
        do_reset();
        for (int i = 0; i < 16; i++) begin
            send_bits(8'(8'h10 + i), 8);
        end
        chk("pp_full", int'(full_fifo), 1);
        send_bits(8'hEE, 7);
        tdo = 1'b1;
        tck = 1'b1;
        tick();
        tck = 1'b0;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("pp_count", int'(data_count), 16);
        chk("pp_ovf", int'(overflow), 0);
        for (int i = 1; i < 16; i++) begin
            pop_chk($sformatf("pp_rd%0d", i), 8'(8'h10 + i));
        end
        pop_chk("pp_last", 8'hEE);
        chk("pp_drain", int'(empty_fifo), 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
